// File: rtl/ram_bus_responder_pkg.sv
// Shared state encoding, bus widths and timing constants for the RAM bus responder.
package ram_bus_responder_pkg;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 16;
    localparam int RAM_ADDR_W = 18;

    localparam int WR_PULSE_CYCLES = 1;
    localparam int RD_SETUP_CYCLES = 2;

    // 4 bits wide so the state can be shown directly on the shared state display.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_W_SETUP  = 4'd1,
        S_W_PULSE  = 4'd2,
        S_W_HOLD   = 4'd3,
        S_R_SETUP  = 4'd4,
        S_R_SAMPLE = 4'd5
    } state_e;

endpackage

// File: rtl/ram_bus_responder_sram_port.sv
// One SRAM chip interface: tristate data driver, address/control outputs and read-data tap.
module sram_port
    import ram_bus_responder_pkg::*;
(
    input  logic                  sel_i,
    input  logic                  active_i,
    input  logic                  drive_i,
    input  logic                  read_i,
    input  logic                  strobe_i,
    input  logic [DATA_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    inout  wire  [DATA_W-1:0]     ram_data_io,
    output logic                  ram_en_o,
    output logic                  ram_oe_o,
    output logic                  ram_we_o,
    output logic [DATA_W-1:0]     rdata_o
);

    logic on;

    assign on         = sel_i & active_i;
    assign ram_en_o   = ~on;
    assign ram_oe_o   = ~(on & read_i);
    assign ram_we_o   = ~(on & strobe_i);
    assign ram_addr_o = on ? {2'b00, addr_i} : '0;

    // Never drive while the chip's output enable is active, whatever the FSM asks for.
    assign ram_data_io = (on & drive_i & ~read_i) ? wdata_i : 'z;
    assign rdata_o     = ram_data_io;

endmodule

// File: rtl/ram_bus_responder.sv
// Bus responder that turns level read/write requests into timed accesses on two async SRAMs.
module ram_bus_responder
    import ram_bus_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  done,
    output logic [RAM_ADDR_W-1:0] ram_addr1,
    output logic [RAM_ADDR_W-1:0] ram_addr2,
    inout  wire  [DATA_W-1:0]     ram_data1,
    inout  wire  [DATA_W-1:0]     ram_data2,
    output logic                  ram1EN,
    output logic                  ram2EN,
    output logic                  ram1OE,
    output logic                  ram2OE,
    output logic                  ram1WE,
    output logic                  ram2WE
);

    state_e              state_q, state_d;
    logic                cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [DATA_W-1:0]   rdata1, rdata2;
    logic                active, drive, rd, strobe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        case (state_q)
            S_IDLE: begin
                // A write wins when both request lines are high.
                if (en && we) begin
                    state_d = S_W_SETUP;
                    addr_d  = addr;
                    wdata_d = data_in;
                end else if (en && re) begin
                    state_d = S_R_SETUP;
                    addr_d  = addr;
                end
            end
            S_W_SETUP: begin
                state_d = S_W_PULSE;
                cnt_d   = 1'b0;
            end
            S_W_PULSE: begin
                if (cnt_q == 1'(WR_PULSE_CYCLES - 1)) begin
                    state_d = S_W_HOLD;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_W_HOLD: state_d = S_IDLE;
            S_R_SETUP: begin
                if (cnt_q == 1'(RD_SETUP_CYCLES - 1)) begin
                    state_d = S_R_SAMPLE;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_R_SAMPLE: begin
                state_d    = S_IDLE;
                data_out_d = addr_q[DATA_W] ? rdata2 : rdata1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active = (state_q != S_IDLE);
        drive  = (state_q == S_W_SETUP) || (state_q == S_W_PULSE) || (state_q == S_W_HOLD);
        rd     = (state_q == S_R_SETUP) || (state_q == S_R_SAMPLE);
        strobe = (state_q == S_W_PULSE);
    end

    assign done     = ~active;
    assign data_out = data_out_q;

    sram_port u_ram1 (
        .sel_i       (~addr_q[DATA_W]),
        .active_i    (active),
        .drive_i     (drive),
        .read_i      (rd),
        .strobe_i    (strobe),
        .addr_i      (addr_q[DATA_W-1:0]),
        .wdata_i     (wdata_q),
        .ram_addr_o  (ram_addr1),
        .ram_data_io (ram_data1),
        .ram_en_o    (ram1EN),
        .ram_oe_o    (ram1OE),
        .ram_we_o    (ram1WE),
        .rdata_o     (rdata1)
    );

    sram_port u_ram2 (
        .sel_i       (addr_q[DATA_W]),
        .active_i    (active),
        .drive_i     (drive),
        .read_i      (rd),
        .strobe_i    (strobe),
        .addr_i      (addr_q[DATA_W-1:0]),
        .wdata_i     (wdata_q),
        .ram_addr_o  (ram_addr2),
        .ram_data_io (ram_data2),
        .ram_en_o    (ram2EN),
        .ram_oe_o    (ram2OE),
        .ram_we_o    (ram2WE),
        .rdata_o     (rdata2)
    );

endmodule

// File: tb/tb_ram_bus_responder.sv
// Directed bench for ram_bus_responder with behavioural models of both SRAM chips.
module tb_ram_bus_responder;

    logic        clk = 1'b0;
    logic        rst, en, re, we;
    logic [16:0] addr;
    logic [15:0] data_in;
    wire  [15:0] data_out;
    wire         done;
    wire  [17:0] ram_addr1, ram_addr2;
    wire  [15:0] ram_data1, ram_data2;
    wire         ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE;

    always #5 clk = ~clk;

    ram_bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .done      (done),
        .ram_addr1 (ram_addr1),
        .ram_addr2 (ram_addr2),
        .ram_data1 (ram_data1),
        .ram_data2 (ram_data2),
        .ram1EN    (ram1EN),
        .ram2EN    (ram2EN),
        .ram1OE    (ram1OE),
        .ram2OE    (ram2OE),
        .ram1WE    (ram1WE),
        .ram2WE    (ram2WE)
    );

    // SRAM models: drive the bus only for a read, capture the bus while WE is low.
    logic [15:0] mem1 [0:63];
    logic [15:0] mem2 [0:63];

    assign ram_data1 = (!ram1EN && !ram1OE && ram1WE) ? mem1[ram_addr1[5:0]] : 16'bz;
    assign ram_data2 = (!ram2EN && !ram2OE && ram2WE) ? mem2[ram_addr2[5:0]] : 16'bz;

    always @(posedge clk) begin
        if (!ram1EN && !ram1WE) mem1[ram_addr1[5:0]] <= ram_data1;
        if (!ram2EN && !ram2WE) mem2[ram_addr2[5:0]] <= ram_data2;
    end

    // Per-cycle activity counters sampled mid-cycle.
    int we1_lo = 0, we2_lo = 0, oe1_lo = 0, oe2_lo = 0, en2_lo = 0, both_en = 0, ctl_act = 0;

    always @(negedge clk) begin
        if (!ram1WE) we1_lo <= we1_lo + 1;
        if (!ram2WE) we2_lo <= we2_lo + 1;
        if (!ram1OE) oe1_lo <= oe1_lo + 1;
        if (!ram2OE) oe2_lo <= oe2_lo + 1;
        if (!ram2EN) en2_lo <= en2_lo + 1;
        if (!ram1EN && !ram2EN) both_en <= both_en + 1;
        if (!done || !ram1EN || !ram2EN || !ram1OE || !ram2OE || !ram1WE || !ram2WE)
            ctl_act <= ctl_act + 1;
    end

    int passed = 0, total = 0, failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int s_we1, s_we2, s_oe1, s_oe2, s_en2, s_act;

    task automatic snap();
        s_we1 = we1_lo; s_we2 = we2_lo; s_oe1 = oe1_lo;
        s_oe2 = oe2_lo; s_en2 = en2_lo; s_act = ctl_act;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; re = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        tick(); tick();

        chk("rst_done", 32'(done), 32'h1);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_ctl", 32'({ram1EN, ram2EN, ram1OE, ram2OE, ram1WE, ram2WE}), 32'h3f);
        chk("rst_addr1", 32'(ram_addr1), 32'h0);
        chk("rst_addr2", 32'(ram_addr2), 32'h0);
        rst = 1'b1;
        tick();

        // Write 0x1234 to RAM1[5]
        snap();
        en = 1'b1; we = 1'b1; addr = 17'h00005; data_in = 16'h1234;
        tick();
        we = 1'b0;
        chk("w1_setup_done", 32'(done), 32'h0);
        chk("w1_setup_ctl", 32'({ram1EN, ram1OE, ram1WE}), 32'h3);
        chk("w1_setup_bus", 32'(ram_data1), 32'h1234);
        tick();
        chk("w1_pulse_we", 32'(ram1WE), 32'h0);
        chk("w1_pulse_bus", 32'(ram_data1), 32'h1234);
        chk("w1_pulse_addr", 32'(ram_addr1), 32'h5);
        tick();
        chk("w1_hold_we", 32'(ram1WE), 32'h1);
        chk("w1_hold_bus", 32'(ram_data1), 32'h1234);
        chk("w1_hold_done", 32'(done), 32'h0);
        tick();
        chk("w1_done", 32'(done), 32'h1);
        chk("w1_we1_cycles", 32'(we1_lo - s_we1), 32'h1);
        chk("w1_we2_cycles", 32'(we2_lo - s_we2), 32'h0);
        chk("w1_en2_cycles", 32'(en2_lo - s_en2), 32'h0);
        chk("w1_mem", 32'(mem1[5]), 32'h1234);

        // Load RAM2[5] = 0xBEEF through the responder
        we = 1'b1; addr = 17'h10005; data_in = 16'hBEEF;
        tick();
        we = 1'b0;
        tick(); tick(); tick();
        chk("w2_mem", 32'(mem2[5]), 32'hBEEF);
        chk("w2_ram1_kept", 32'(mem1[5]), 32'h1234);

        // Read RAM2[5]
        snap();
        re = 1'b1; addr = 17'h10005;
        tick();
        re = 1'b0;
        chk("r_setup_done", 32'(done), 32'h0);
        chk("r_setup_ctl2", 32'({ram2EN, ram2OE, ram2WE}), 32'h1);
        chk("r_setup_en1", 32'(ram1EN), 32'h1);
        chk("r_setup_addr2", 32'(ram_addr2), 32'h5);
        chk("r_setup_addr1", 32'(ram_addr1), 32'h0);
        tick(); tick();
        chk("r_sample_oe", 32'(ram2OE), 32'h0);
        chk("r_sample_bus", 32'(ram_data2), 32'hBEEF);
        chk("r_sample_dout_old", 32'(data_out), 32'h0);
        tick();
        chk("r_done", 32'(done), 32'h1);
        chk("r_data_out", 32'(data_out), 32'hBEEF);
        chk("r_oe2_cycles", 32'(oe2_lo - s_oe2), 32'h3);
        chk("r_oe1_cycles", 32'(oe1_lo - s_oe1), 32'h0);

        // Simultaneous re and we: treated as a write
        snap();
        re = 1'b1; we = 1'b1; addr = 17'h00010; data_in = 16'h00AA;
        tick();
        re = 1'b0; we = 1'b0;
        chk("rw_setup_ctl", 32'({ram1EN, ram1OE, ram1WE}), 32'h3);
        tick(); tick(); tick();
        chk("rw_done", 32'(done), 32'h1);
        chk("rw_oe1_cycles", 32'(oe1_lo - s_oe1), 32'h0);
        chk("rw_we1_cycles", 32'(we1_lo - s_we1), 32'h1);
        chk("rw_mem", 32'(mem1[16]), 32'h00AA);
        chk("rw_data_out", 32'(data_out), 32'hBEEF);

        // Disabled: requests ignored
        snap();
        en = 1'b0; we = 1'b1; addr = 17'h00022; data_in = 16'h9999;
        repeat (10) tick();
        chk("dis_activity", 32'(ctl_act - s_act), 32'h0);
        chk("dis_done", 32'(done), 32'h1);
        we = 1'b0; en = 1'b1;

        // Reset during the write pulse
        snap();
        we = 1'b1; addr = 17'h00020; data_in = 16'h7777;
        tick();
        we = 1'b0;
        tick();
        chk("ab_pulse_we", 32'(ram1WE), 32'h0);
        rst = 1'b0;
        tick();
        chk("ab_we", 32'(ram1WE), 32'h1);
        chk("ab_done", 32'(done), 32'h1);
        chk("ab_data_out", 32'(data_out), 32'h0);
        chk("ab_en1", 32'(ram1EN), 32'h1);
        chk("ab_addr1", 32'(ram_addr1), 32'h0);
        rst = 1'b1;
        tick(); tick();
        chk("ab_we1_cycles", 32'(we1_lo - s_we1), 32'h1);
        we = 1'b1; addr = 17'h00030; data_in = 16'h5555;
        tick();
        we = 1'b0;
        chk("ab2_busy", 32'(done), 32'h0);
        tick(); tick(); tick();
        chk("ab2_done", 32'(done), 32'h1);
        chk("ab2_mem", 32'(mem1[48]), 32'h5555);

        // Ten back-to-back writes with we held high, then ten reads
        we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addr = 17'(i); data_in = 16'h0100 + 16'(i);
            tick(); tick(); tick(); tick();
        end
        we = 1'b0;
        re = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addr = 17'(i);
            tick(); tick(); tick(); tick();
            chk($sformatf("b2b_read_%0d", i), 32'(data_out), 32'h0100 + 32'(i));
        end
        re = 1'b0;
        tick();
        chk("b2b_done", 32'(done), 32'h1);
        chk("both_en_cycles", 32'(both_en), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
